// File: rtl/alu32_checker.sv
`default_nettype none
// ==========================================================================
// alu32_checker: two-stage (capture/retire) golden-model monitor for alu32.
// Revision 1.0 - initial release
// ==========================================================================
module alu32_checker #(
  parameter int COUNT_W      = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               finish,
  input  logic               valid,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  input  logic [2:0]         control,
  input  logic [31:0]        out,
  input  logic               overflow,
  input  logic               zero,
  input  logic               negative,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               mismatch,
  output logic [COUNT_W-1:0] check_count,
  output logic [COUNT_W-1:0] err_count,
  output logic [COUNT_W-1:0] fail_index,
  output logic [34:0]        fail_expected,
  output logic [34:0]        fail_got
);

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic        cap_valid;
  logic [2:0]  cap_ctrl;
  logic [31:0] cap_a, cap_b, cap_out;
  logic [2:0]  cap_flags;
  logic [31:0] exp_out;
  logic        exp_ovf;
  logic [34:0] exp_vec, got_vec;
  logic        retire, retire_fail, stop_now, capture;

  always_comb begin
    exp_out = '0;
    exp_ovf = 1'b0;
    case (cap_ctrl)
      ALU_ADD: begin
        exp_out = cap_a + cap_b;
        exp_ovf = (cap_a[31] == cap_b[31]) && (exp_out[31] != cap_a[31]);
      end
      ALU_SUB: begin
        exp_out = cap_a - cap_b;
        exp_ovf = (cap_a[31] != cap_b[31]) && (exp_out[31] != cap_a[31]);
      end
      ALU_AND: exp_out = cap_a & cap_b;
      ALU_OR:  exp_out = cap_a | cap_b;
      ALU_NOR: exp_out = ~(cap_a | cap_b);
      ALU_XOR: exp_out = cap_a ^ cap_b;
      default: exp_out = '0;
    endcase
  end

  assign exp_vec     = {exp_ovf, (exp_out == 32'd0), exp_out[31], exp_out};
  assign got_vec     = {cap_flags, cap_out};
  // start flushes the pipeline, so an in-flight vector never retires on that edge
  assign retire      = cap_valid && !start;
  assign retire_fail = retire && (exp_vec != got_vec);
  assign stop_now    = STOP_ON_FAIL && retire_fail;
  assign capture     = (state == CHECK) && valid && (control >= ALU_ADD) && !start && !stop_now;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   if (start) state_nxt = CHECK;
               else if (finish || stop_now) state_nxt = DONE;
      DONE:    if (start) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_valid     <= 1'b0;
      cap_ctrl      <= '0;
      cap_a         <= '0;
      cap_b         <= '0;
      cap_out       <= '0;
      cap_flags     <= '0;
      mismatch      <= 1'b0;
      check_count   <= '0;
      err_count     <= '0;
      fail_index    <= '0;
      fail_expected <= '0;
      fail_got      <= '0;
    end else begin
      mismatch  <= 1'b0;
      cap_valid <= capture;
      if (capture) begin
        cap_ctrl  <= control;
        cap_a     <= A;
        cap_b     <= B;
        cap_out   <= out;
        cap_flags <= {overflow, zero, negative};
      end
      if (start) begin
        check_count   <= '0;
        err_count     <= '0;
        fail_index    <= '0;
        fail_expected <= '0;
        fail_got      <= '0;
      end else if (retire) begin
        if (check_count != CNT_MAX) check_count <= check_count + CNT_ONE;
        if (retire_fail) begin
          mismatch <= 1'b1;
          if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
          // err_count saturates above zero, so zero reliably marks "no failure yet"
          if (err_count == '0) begin
            fail_index    <= check_count;
            fail_expected <= exp_vec;
            fail_got      <= got_vec;
          end
        end
      end
    end
  end

  assign busy = (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu32_checker.sv
`default_nettype none
// Scoreboard bench for alu32_checker: a 16-bit free-running instance plus a
// COUNT_W=4, STOP_ON_FAIL=1 instance sharing the same stimulus.
module tb_alu32_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, finish = 1'b0, valid = 1'b0;
  logic [31:0] A = '0, B = '0, out = '0;
  logic [2:0]  control = '0;
  logic        overflow = 1'b0, zero = 1'b0, negative = 1'b0;

  logic        busy, done, pass, mismatch;
  logic [15:0] check_count, err_count, fail_index;
  logic [34:0] fail_expected, fail_got;

  logic        s_busy, s_done, s_pass, s_mismatch;
  logic [3:0]  s_check_count, s_err_count, s_fail_index;
  logic [34:0] s_fail_expected, s_fail_got;

  alu32_checker #(.COUNT_W(16), .STOP_ON_FAIL(1'b0)) u_dut (
    .clock(clock), .reset(reset), .start(start), .finish(finish), .valid(valid),
    .A(A), .B(B), .control(control), .out(out), .overflow(overflow), .zero(zero),
    .negative(negative), .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .check_count(check_count), .err_count(err_count), .fail_index(fail_index),
    .fail_expected(fail_expected), .fail_got(fail_got)
  );

  alu32_checker #(.COUNT_W(4), .STOP_ON_FAIL(1'b1)) u_sat (
    .clock(clock), .reset(reset), .start(start), .finish(finish), .valid(valid),
    .A(A), .B(B), .control(control), .out(out), .overflow(overflow), .zero(zero),
    .negative(negative), .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
    .check_count(s_check_count), .err_count(s_err_count), .fail_index(s_fail_index),
    .fail_expected(s_fail_expected), .fail_got(s_fail_got)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fail;
    logic [15:0] idx;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        running = 1'b0;
  logic [15:0] issued = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference ALU: signed overflow judged by whether the true integer result fits 32 bits
  function automatic logic [34:0] golden(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    v = 1'b0;
    case (c)
      3'd2: begin s = sa + sb; r = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd3: begin s = sa - sb; r = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~(a | b);
      3'd7: r = a ^ b;
      default: r = '0;
    endcase
    return {v, (r == 32'd0), r[31], r};
  endfunction

  task automatic send(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [34:0] resp, input logic st, input logic fin);
    exp_t e;
    @(negedge clock);
    start = st; finish = fin; valid = v; control = c; A = a; B = b;
    {overflow, zero, negative, out} = resp;
    if (st) begin
      sb_q.delete();
      issued  = '0;
      running = 1'b1;
    end else if (running && v && c >= 3'd2) begin
      e.fail = (resp != golden(c, a, b));
      e.idx  = issued;
      sb_q.push_back(e);
      issued++;
    end
    if (fin && !st) running = 1'b0;
  endtask

  task automatic idle(input logic st, input logic fin);
    send(1'b0, 3'd0, 32'd0, 32'd0, 35'd0, st, fin);
  endtask

  task automatic send_ok();
    logic [2:0]  c;
    logic [31:0] a, b;
    c = 3'($urandom_range(2, 7));
    a = $urandom();
    b = $urandom();
    send(1'b1, c, a, b, golden(c, a, b), 1'b0, 1'b0);
  endtask

  task automatic send_bad();
    logic [2:0]  c;
    logic [31:0] a, b;
    logic [34:0] r;
    c = 3'($urandom_range(2, 7));
    a = $urandom();
    b = $urandom();
    r = golden(c, a, b) ^ (35'd1 << $urandom_range(0, 34));
    send(1'b1, c, a, b, r, 1'b0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #2;
  endtask

  // Monitor: every increment of check_count is a retired vector to match against the queue
  initial begin
    logic [15:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset && check_count == prev + 16'd1) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_retire", 64'(check_count), 64'(prev));
        end else begin
          e = sb_q.pop_front();
          check("sb_mismatch", 64'(mismatch), 64'(e.fail));
          check("sb_check_count", 64'(check_count), 64'(e.idx) + 64'd1);
        end
      end else begin
        check("sb_no_spurious_mismatch", 64'(mismatch), 64'd0);
      end
      prev = check_count;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  logic [2:0]  t_c[11]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3};
  logic [31:0] t_a[11]  = '{32'h8, 32'h2, 32'h3, 32'h4, 32'h1, 32'h5, 32'h6, 32'h3,
                            32'h7FFFFFFF, 32'hFF89B1E5, 32'hFFC9C825};
  logic [31:0] t_b[11]  = '{32'h4, 32'h5, 32'h7, 32'h2, 32'h8, 32'h6, 32'h6, 32'h7FFFFFFF,
                            32'h7FFFFFFF, 32'hFFC9C825, 32'h7FFFFFFF};
  logic [34:0] t_r[11]  = '{{3'b000, 32'h0000000C}, {3'b001, 32'hFFFFFFFD}, {3'b000, 32'h00000003},
                            {3'b000, 32'h00000006}, {3'b001, 32'hFFFFFFF6}, {3'b000, 32'h00000003},
                            {3'b010, 32'h00000000}, {3'b001, 32'h80000004}, {3'b101, 32'hFFFFFFFE},
                            {3'b001, 32'hFF537A0A}, {3'b100, 32'h7FC9C826}};

  initial begin
    // Reset held with activity on the inputs
    valid = 1'b1; start = 1'b1; control = 3'd2; A = $urandom(); B = $urandom(); out = $urandom();
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("rst_outputs", 64'({busy, done, pass, mismatch}), 64'd0);
      check("rst_counts", 64'({check_count, err_count, fail_index}), 64'd0);
      check("rst_capture", 64'({fail_expected, s_check_count, s_busy}), 64'd0);
    end
    @(negedge clock);
    reset = 1'b1; start = 1'b0; valid = 1'b0;
    after_edge();
    check("idle_after_reset", 64'({busy, done}), 64'd0);

    // Clean run with known vectors
    idle(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) send(1'b1, t_c[i], t_a[i], t_b[i], t_r[i], 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    after_edge();
    check("clean_count", 64'(check_count), 64'd11);
    check("clean_err", 64'(err_count), 64'd0);
    check("clean_pass", 64'({done, pass, busy}), 64'b110);

    // Injected overflow fault at vector index 5
    idle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) send(1'b1, 3'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, {3'b001, 32'hFFFFFFFE}, 1'b0, 1'b0);
      else send_ok();
      if (i == 6) begin
        after_edge();
        check("fault_mismatch", 64'(mismatch), 64'd1);
        check("fault_err", 64'(err_count), 64'd1);
        check("fault_index", 64'(fail_index), 64'd5);
        check("fault_expected", 64'(fail_expected), 64'({3'b101, 32'hFFFFFFFE}));
        check("fault_got", 64'(fail_got), 64'({3'b001, 32'hFFFFFFFE}));
      end
    end
    idle(1'b0, 1'b1);
    after_edge();
    check("fault_pass", 64'({done, pass}), 64'b10);
    check("fault_count", 64'({check_count, err_count}), 64'({16'd10, 16'd1}));

    // Skip opcodes with garbage responses
    idle(1'b1, 1'b0);
    send_ok();
    send(1'b1, 3'd0, $urandom(), $urandom(), 35'h5A5A5A5A5, 1'b0, 1'b0);
    send(1'b1, 3'd1, $urandom(), $urandom(), 35'h123456789, 1'b0, 1'b0);
    send_ok();
    idle(1'b0, 1'b1);
    after_edge();
    check("skip_count", 64'({check_count, err_count}), 64'({16'd2, 16'd0}));
    check("skip_pass", 64'(pass), 64'd1);

    // STOP_ON_FAIL instance: fault at index 3 with valid held high
    idle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) send_bad();
      else send_ok();
      if (i == 4) begin
        after_edge();
        check("stop_mismatch", 64'(s_mismatch), 64'd1);
        check("stop_done", 64'({s_done, s_busy}), 64'b10);
      end
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    after_edge();
    check("stop_counts", 64'({s_check_count, s_err_count, s_fail_index}), 64'({4'd4, 4'd1, 4'd3}));
    check("stop_fault_dut", 64'({check_count, err_count, fail_index}), 64'({16'd8, 16'd1, 16'd3}));
    idle(1'b0, 1'b1);

    // Saturation of the 4-bit counters
    idle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send_ok();
    idle(1'b0, 1'b1);
    after_edge();
    check("sat_count", 64'({s_check_count, s_err_count}), 64'({4'd15, 4'd0}));
    check("sat_pass", 64'(s_pass), 64'd1);
    check("sat_dut_count", 64'(check_count), 64'd20);

    // start while a faulty vector is in flight, with a concurrent valid
    idle(1'b1, 1'b0);
    send_ok();
    send_bad();
    send(1'b1, 3'd2, 32'd1, 32'd2, golden(3'd2, 32'd1, 32'd2), 1'b1, 1'b0);
    after_edge();
    check("flush_counts", 64'({check_count, err_count, fail_index}), 64'd0);
    check("flush_sat", 64'({s_check_count, s_busy}), 64'({4'd0, 1'b1}));
    idle(1'b0, 1'b0);
    after_edge();
    check("flush_no_capture", 64'({check_count, mismatch}), 64'd0);

    // Reset pulse mid-run after a failure has been captured
    send_bad();
    send_ok();
    send_ok();
    @(negedge clock);
    reset = 1'b0; valid = 1'b0;
    sb_q.delete();
    running = 1'b0;
    #1;
    check("async_rst_state", 64'({busy, done, pass, mismatch}), 64'd0);
    check("async_rst_counts", 64'({check_count, err_count, fail_index}), 64'd0);
    check("async_rst_capture", 64'({fail_expected, fail_got}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    after_edge();
    check("post_rst_idle", 64'({busy, done, check_count}), 64'd0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
